// File: rtl/axis_1553_pkg.sv
// Shared definitions for the 1553 bus-controller transmit path.
// Contents: encoder sync codes, tuser bit positions, command-word field offsets,
// sequencer state enum, the command-word length decoder and a tuser builder.
package axis_1553_pkg;

  // Sync patterns in tuser[7:5]
  localparam logic [2:0] SYNC_CMD  = 3'b100;
  localparam logic [2:0] SYNC_DATA = 3'b010;

  // tuser bit positions
  localparam int unsigned TU_SYNC_LSB = 5;
  localparam int unsigned TU_GAP      = 2;
  localparam int unsigned TU_INV      = 1;
  localparam int unsigned TU_PAR      = 0;

  // Command-word fields: RT[15:11], T/R[10], SA[9:5], WC/MC[4:0]
  localparam int unsigned CW_TR     = 10;
  localparam int unsigned CW_SA_LSB = 5;
  localparam int unsigned CW_WC_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StData,
    StDone,
    StErr
  } state_e;

  // Number of data words that follow the command word.
  function automatic logic [5:0] wc_decode(input logic [15:0] cmd, input logic sa31_en);
    logic [4:0] sa;
    logic [4:0] wc;
    logic [5:0] rem;
    sa = cmd[CW_SA_LSB +: 5];
    wc = cmd[CW_WC_LSB +: 5];
    if (cmd[CW_TR]) begin
      rem = 6'd0;                       // RT transmits; BC sends the command only
    end else if ((sa == 5'd0) || (sa31_en && (sa == 5'd31))) begin
      rem = {5'd0, wc[4]};              // mode codes 16..31 carry one data word
    end else if (wc == 5'd0) begin
      rem = 6'd32;
    end else begin
      rem = {1'b0, wc};
    end
    return rem;
  endfunction

  function automatic logic [7:0] make_tuser(input logic [2:0] sync, input logic gap,
                                            input logic par);
    logic [7:0] tu;
    tu                    = '0;
    tu[TU_SYNC_LSB +: 3]  = sync;
    tu[TU_GAP]            = gap;
    tu[TU_INV]            = 1'b0;
    tu[TU_PAR]            = par;
    return tu;
  endfunction

endpackage

// File: rtl/axis_1553_out_reg.sv
// AXI-Stream output register (16-bit tdata, 8-bit tuser) with load/hold.
// Ports:
//   aclk, arstn        clock, synchronous active-low reset
//   load_i             capture tdata_i/tuser_i and assert tvalid_o
//   clear_i            drop the held word (only used while tvalid_o is low)
//   tdata_i, tuser_i   word to capture
//   tready_i           downstream ready; an accept empties the register
//   tvalid_o, tdata_o, tuser_o  registered stream outputs
module axis_1553_out_reg (
  input  logic        aclk,
  input  logic        arstn,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [15:0] tdata_i,
  input  logic [7:0]  tuser_i,
  input  logic        tready_i,
  output logic        tvalid_o,
  output logic [15:0] tdata_o,
  output logic [7:0]  tuser_o
);

  logic        valid_q;
  logic [15:0] data_q;
  logic [7:0]  user_q;

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      // The caller only loads when the register is empty or being accepted.
      valid_q <= 1'b1;
      data_q  <= tdata_i;
      user_q  <= tuser_i;
    end else if (tready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign tvalid_o = valid_q;
  assign tdata_o  = data_q;
  assign tuser_o  = user_q;

endmodule

// File: rtl/axis_1553_tx_sequencer.sv
// 1553 bus-controller transmit sequencer in front of the Manchester encoder.
// Takes one command-word descriptor, derives the message length, then streams
// the command word and the required data words to the encoder with the proper
// sync/gap/parity control in tuser. Aborts on data starvation.
// Ports:
//   aclk, arstn                     clock, synchronous active-low reset
//   s_msg_*                         command descriptor (tuser = parity-error inject)
//   s_dat_*                         data word stream
//   m_axis_*                        encoder stream (tuser = sync/gap/invert/parity)
//   busy                            message in progress
//   msg_done, msg_err               one-cycle completion / timeout pulses
//   err_count                       saturating timeout count
module axis_1553_tx_sequencer
  import axis_1553_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4000,
  parameter bit          MODE_SA31_EN   = 1'b1
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [15:0] s_msg_tdata,
  input  logic        s_msg_tuser,
  input  logic        s_msg_tvalid,
  output logic        s_msg_tready,
  input  logic [15:0] s_dat_tdata,
  input  logic        s_dat_tvalid,
  output logic        s_dat_tready,
  output logic [15:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        msg_done,
  output logic        msg_err,
  output logic [7:0]  err_count
);

  localparam int unsigned     TmoW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic            inj_q;
  logic [5:0]      wc_q;       // total data words in this message
  logic [5:0]      fetched_q;  // data words taken from s_dat
  logic [5:0]      left_q;     // data words not yet accepted by the encoder
  logic [TmoW-1:0] tmo_q;
  logic [7:0]      err_count_q;
  logic            msg_done_q;
  logic            msg_err_q;

  logic        msg_accept;
  logic        dat_accept;
  logic        enc_accept;
  logic        out_free;
  logic        out_load;
  logic        waiting;
  logic        tmo_abort;
  logic        last_fetch;
  logic [5:0]  msg_rem;
  logic [15:0] ld_data;
  logic [7:0]  ld_user;

  // Gated with arstn so no descriptor is offered while reset is held.
  assign s_msg_tready = arstn && (state_q == StIdle);
  assign msg_accept   = s_msg_tvalid && s_msg_tready;
  assign msg_rem      = wc_decode(s_msg_tdata, MODE_SA31_EN);

  assign out_free     = !m_axis_tvalid || m_axis_tready;
  assign enc_accept   = m_axis_tvalid && m_axis_tready;
  assign s_dat_tready = (state_q == StData) && out_free && (fetched_q < wc_q);
  assign dat_accept   = s_dat_tvalid && s_dat_tready;
  assign last_fetch   = (fetched_q == (wc_q - 6'd1));

  // Timeout may only fire with nothing held for the encoder.
  assign waiting   = (state_q == StData) && (fetched_q < wc_q) && !dat_accept;
  assign tmo_abort = waiting && !m_axis_tvalid && (tmo_q == TmoLast);

  assign out_load = msg_accept || dat_accept;

  always_comb begin
    ld_data = s_dat_tdata;
    ld_user = make_tuser(SYNC_DATA, 1'b0, inj_q && last_fetch);
    if (state_q == StIdle) begin
      ld_data = s_msg_tdata;
      // A command-only message carries the parity inject on the command word.
      ld_user = make_tuser(SYNC_CMD, 1'b1, s_msg_tuser && (msg_rem == 6'd0));
    end
  end

  axis_1553_out_reg u_out_reg (
    .aclk     (aclk),
    .arstn    (arstn),
    .load_i   (out_load),
    .clear_i  (tmo_abort),
    .tdata_i  (ld_data),
    .tuser_i  (ld_user),
    .tready_i (m_axis_tready),
    .tvalid_o (m_axis_tvalid),
    .tdata_o  (m_axis_tdata),
    .tuser_o  (m_axis_tuser)
  );

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state_q     <= StIdle;
      inj_q       <= 1'b0;
      wc_q        <= '0;
      fetched_q   <= '0;
      left_q      <= '0;
      tmo_q       <= '0;
      err_count_q <= '0;
      msg_done_q  <= 1'b0;
      msg_err_q   <= 1'b0;
    end else begin
      msg_done_q <= 1'b0;
      msg_err_q  <= 1'b0;

      if ((state_q != StData) || dat_accept) begin
        tmo_q <= '0;
      end else if (waiting && (tmo_q != TmoLast)) begin
        tmo_q <= tmo_q + TmoW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (msg_accept) begin
            inj_q     <= s_msg_tuser;
            wc_q      <= msg_rem;
            left_q    <= msg_rem;
            fetched_q <= '0;
            state_q   <= StCmd;
          end
        end
        StCmd: begin
          if (enc_accept) begin
            if (wc_q == 6'd0) begin
              state_q    <= StDone;
              msg_done_q <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (dat_accept) begin
            fetched_q <= fetched_q + 6'd1;
          end
          if (tmo_abort) begin
            state_q   <= StErr;
            msg_err_q <= 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_q <= err_count_q + 8'd1;
            end
          end else if (enc_accept) begin
            left_q <= left_q - 6'd1;
            if (left_q == 6'd1) begin
              state_q    <= StDone;
              msg_done_q <= 1'b1;
            end
          end
        end
        StDone, StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign msg_done  = msg_done_q;
  assign msg_err   = msg_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_axis_1553_tx_sequencer.sv
// Directed bench for axis_1553_tx_sequencer: one linear stimulus sequence,
// immediate assertions at each comparison point.
module tb_axis_1553_tx_sequencer;

  localparam int unsigned Tmo = 40;

  logic        aclk;
  logic        arstn;
  logic [15:0] s_msg_tdata;
  logic        s_msg_tuser;
  logic        s_msg_tvalid;
  logic        s_msg_tready;
  logic [15:0] s_dat_tdata;
  logic        s_dat_tvalid;
  logic        s_dat_tready;
  logic [15:0] m_axis_tdata;
  logic [7:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        busy;
  logic        msg_done;
  logic        msg_err;
  logic [7:0]  err_count;

  axis_1553_tx_sequencer #(
    .TIMEOUT_CYCLES (Tmo),
    .MODE_SA31_EN   (1'b1)
  ) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .s_msg_tdata   (s_msg_tdata),
    .s_msg_tuser   (s_msg_tuser),
    .s_msg_tvalid  (s_msg_tvalid),
    .s_msg_tready  (s_msg_tready),
    .s_dat_tdata   (s_dat_tdata),
    .s_dat_tvalid  (s_dat_tvalid),
    .s_dat_tready  (s_dat_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .msg_done      (msg_done),
    .msg_err       (msg_err),
    .err_count     (err_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rdy_mode = 0;      // 0: ready, 1: 3 on / 3 off, 2: stalled
  logic [23:0] out_q[$];          // {tdata, tuser} accepted by the encoder
  logic [15:0] src_q[$];          // pending upstream data words
  int          done_cnt, err_cnt, dat_rdy_seen, stall_seen, stab_viol;
  int          last_dat_cyc, err_cyc;
  logic        msg_acc;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input int idx, input logic [23:0] exp);
    logic [23:0] got;
    got = 'x;
    if (idx < out_q.size()) got = out_q[idx];
    check(tag, {8'h0, got}, {8'h0, exp});
  endtask

  task automatic drive();
    s_dat_tvalid = (src_q.size() != 0);
    s_dat_tdata  = (src_q.size() != 0) ? src_q[0] : 16'h0;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ((cyc / 3) % 2) == 0;
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  // One clock: observe handshakes at the negedge, update drivers after the posedge.
  task automatic step();
    logic        dat_acc;
    logic        enc_acc;
    logic [15:0] tmp;
    @(negedge aclk);
    dat_acc = s_dat_tvalid && s_dat_tready;
    enc_acc = m_axis_tvalid && m_axis_tready;
    msg_acc = s_msg_tvalid && s_msg_tready;
    if (enc_acc) out_q.push_back({m_axis_tdata, m_axis_tuser});
    if (dat_acc) last_dat_cyc = cyc;
    if (msg_done) done_cnt++;
    if (msg_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (s_dat_tready) dat_rdy_seen++;
    if (m_axis_tvalid && !m_axis_tready) stall_seen++;
    if (prev_stall && (!m_axis_tvalid || ({m_axis_tdata, m_axis_tuser} !== prev_word)))
      stab_viol++;
    prev_stall = arstn && m_axis_tvalid && !m_axis_tready;
    prev_word  = {m_axis_tdata, m_axis_tuser};
    @(posedge aclk);
    #1;
    cyc++;
    if (dat_acc) tmp = src_q.pop_front();
    if (msg_acc) s_msg_tvalid = 1'b0;
    drive();
  endtask

  task automatic clear_obs();
    out_q.delete();
    done_cnt = 0; err_cnt = 0; dat_rdy_seen = 0; stall_seen = 0; stab_viol = 0;
    last_dat_cyc = -1; err_cyc = -1;
  endtask

  task automatic start_msg(input logic [15:0] cmd, input logic inj, input string tag);
    logic acc;
    acc = 1'b0;
    s_msg_tdata  = cmd;
    s_msg_tuser  = inj;
    s_msg_tvalid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      step();
      acc = msg_acc;
    end
    s_msg_tvalid = 1'b0;
    check({tag, " accept"}, {31'd0, acc}, 32'd1);
  endtask

  task automatic run_to_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy; i++) step();
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    arstn = 1'b0;
    s_msg_tdata = '0; s_msg_tuser = 1'b0; s_msg_tvalid = 1'b0;
    s_dat_tdata = '0; s_dat_tvalid = 1'b0; m_axis_tready = 1'b1;
    clear_obs();

    // Reset state
    step(); step();
    check("rst tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst tdata", {16'd0, m_axis_tdata}, 32'd0);
    check("rst tuser", {24'd0, m_axis_tuser}, 32'd0);
    check("rst msg_tready", {31'd0, s_msg_tready}, 32'd0);
    check("rst dat_tready", {31'd0, s_dat_tready}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done/err", {30'd0, msg_done, msg_err}, 32'd0);
    check("rst err_count", {24'd0, err_count}, 32'd0);
    arstn = 1'b1;
    #1;
    check("idle msg_tready", {31'd0, s_msg_tready}, 32'd1);

    // Receive, WC=2
    clear_obs();
    src_q.push_back(16'h1234); src_q.push_back(16'hABCD); drive();
    start_msg(16'h0822, 1'b0, "rx2");
    run_to_idle(100, "rx2");
    check("rx2 count", out_q.size(), 32'd3);
    check_word("rx2 w0", 0, 24'h0822_84);
    check_word("rx2 w1", 1, 24'h1234_40);
    check_word("rx2 w2", 2, 24'hABCD_40);
    check("rx2 done", done_cnt, 32'd1);
    check("rx2 err", err_cnt, 32'd0);

    // RT transmit: command only, data stream untouched
    clear_obs();
    src_q.push_back(16'h5555); drive();
    start_msg(16'h0C20, 1'b0, "tx");
    run_to_idle(100, "tx");
    check("tx count", out_q.size(), 32'd1);
    check_word("tx w0", 0, 24'h0C20_84);
    check("tx dat_tready", dat_rdy_seen, 32'd0);
    check("tx src left", src_q.size(), 32'd1);
    check("tx done", done_cnt, 32'd1);

    // Mode code 17 on SA0: one data word
    clear_obs();
    src_q.delete(); src_q.push_back(16'h0F0F); drive();
    start_msg(16'h0011, 1'b0, "mc17");
    run_to_idle(100, "mc17");
    check("mc17 count", out_q.size(), 32'd2);
    check_word("mc17 w1", 1, 24'h0F0F_40);

    // Mode code 2: no data
    clear_obs();
    src_q.push_back(16'h7777); drive();
    start_msg(16'h0002, 1'b0, "mc2");
    run_to_idle(100, "mc2");
    check("mc2 count", out_q.size(), 32'd1);
    check("mc2 src left", src_q.size(), 32'd1);

    // Mode code 17 on SA31
    clear_obs();
    src_q.delete(); src_q.push_back(16'h6666); drive();
    start_msg(16'h03F1, 1'b0, "sa31");
    run_to_idle(100, "sa31");
    check("sa31 count", out_q.size(), 32'd2);
    check_word("sa31 w1", 1, 24'h6666_40);

    // WC=0 means 32 words, encoder ready toggling
    clear_obs();
    for (int i = 0; i < 32; i++) src_q.push_back(16'h1000 + 16'(i));
    rdy_mode = 1; drive();
    start_msg(16'h0820, 1'b0, "wc32");
    run_to_idle(400, "wc32");
    rdy_mode = 0; drive();
    check("wc32 count", out_q.size(), 32'd33);
    check_word("wc32 cmd", 0, 24'h0820_84);
    for (int i = 0; i < 32; i++)
      check_word($sformatf("wc32 word%0d", i), i + 1, {16'h1000 + 16'(i), 8'h40});
    check("wc32 stalled", {31'd0, stall_seen > 0}, 32'd1);
    check("wc32 stable", stab_viol, 32'd0);
    check("wc32 done", done_cnt, 32'd1);

    // WC=3 with only one word available: timeout abort
    clear_obs();
    src_q.push_back(16'h2222); drive();
    start_msg(16'h0823, 1'b0, "tmo");
    run_to_idle(Tmo + 40, "tmo");
    check("tmo err pulse", err_cnt, 32'd1);
    check("tmo no done", done_cnt, 32'd0);
    check("tmo latency", err_cyc - last_dat_cyc, Tmo + 1);
    check("tmo err_count", {24'd0, err_count}, 32'd1);
    check("tmo count", out_q.size(), 32'd2);
    check_word("tmo w1", 1, 24'h2222_40);

    // Inject on WC=1: parity flip on the data word only
    clear_obs();
    src_q.push_back(16'h3333); drive();
    start_msg(16'h0821, 1'b1, "inj1");
    run_to_idle(100, "inj1");
    check_word("inj1 w0", 0, 24'h0821_84);
    check_word("inj1 w1", 1, 24'h3333_41);
    check("inj1 done", done_cnt, 32'd1);
    check("inj1 err_count", {24'd0, err_count}, 32'd1);

    // Inject on WC=2: final word only
    clear_obs();
    src_q.push_back(16'h4444); src_q.push_back(16'h5555); drive();
    start_msg(16'h0822, 1'b1, "inj2");
    run_to_idle(100, "inj2");
    check_word("inj2 w1", 1, 24'h4444_40);
    check_word("inj2 w2", 2, 24'h5555_41);

    // Inject on a command-only message lands on the command word
    clear_obs();
    start_msg(16'h0C20, 1'b1, "injtx");
    run_to_idle(100, "injtx");
    check_word("injtx w0", 0, 24'h0C20_85);

    // Reset mid-DATA with a word held for a stalled encoder
    clear_obs();
    src_q.push_back(16'h7001); drive();
    start_msg(16'h0823, 1'b0, "rstd");
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) step();
    check("rstd held", {31'd0, m_axis_tvalid}, 32'd1);
    arstn = 1'b0;
    step();
    check("rstd tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rstd tdata", {16'd0, m_axis_tdata}, 32'd0);
    check("rstd busy", {31'd0, busy}, 32'd0);
    check("rstd readies", {30'd0, s_msg_tready, s_dat_tready}, 32'd0);
    check("rstd err_count", {24'd0, err_count}, 32'd0);
    arstn = 1'b1;
    rdy_mode = 0;
    src_q.delete(); drive();
    for (int i = 0; i < 5; i++) step();
    check("rstd no pulses", done_cnt + err_cnt, 32'd0);
    check("rstd idle", {30'd0, busy, s_msg_tready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_1553_tx_sequencer.md
Name: axis_1553_tx_sequencer

Overview:
- Bus-controller transmit sequencer placed in front of the existing 1553 Manchester encoder.
- Accepts one message descriptor (a 1553 command word) and a separate stream of data words.
- Derives the message length from the command word and drives the encoder's AXI-Stream slave port: the command word first, then the required data words, with the correct sync/gap/parity control in tuser.
- Reports completion and data-starvation errors to the register/APB layer.

Parameters:
- TIMEOUT_CYCLES, 4000, max aclk cycles to wait for a data word before aborting the message (2 ms at 2 MHz).
- MODE_SA31_EN, 1, 1: subaddress 31 is treated as a mode code in addition to subaddress 0.

Ports:
- aclk  in  1  clock
- arstn  in  1  synchronous active-low reset
- s_msg_tdata  in  16  command word (RT[15:11], T/R[10], SA[9:5], WC/MC[4:0])
- s_msg_tuser  in  1  parity-error inject for this message
- s_msg_tvalid  in  1  descriptor valid
- s_msg_tready  out  1  descriptor accepted
- s_dat_tdata  in  16  data word
- s_dat_tvalid  in  1  data valid
- s_dat_tready  out  1  data accepted
- m_axis_tdata  out  16  word to encoder
- m_axis_tuser  out  8  encoder control: [7:5] sync (100 cmd, 010 data), [2] gap-before, [1] invert=0, [0] parity flip
- m_axis_tvalid  out  1  word valid to encoder
- m_axis_tready  in  1  encoder ready
- busy  out  1  message in progress
- msg_done  out  1  one-cycle pulse when the last word is accepted by the encoder
- msg_err  out  1  one-cycle pulse on timeout abort
- err_count  out  8  saturating timeout counter

Behaviour:
- Reset (arstn=0 at a clock edge): state IDLE. All outputs 0, including err_count, all tready and m_axis_tvalid. Reset mid-message drops the message silently; no done/err pulse is generated.
- States: IDLE, CMD, DATA, DONE, ERR.
- IDLE:
  - s_msg_tready=1.
  - On s_msg_tvalid, latch the command word and inject bit, compute remaining word count rem, go to CMD.
- Word count computation:
  - T/R=1 (RT transmit): rem=0.
  - Mode code (SA=0, or SA=31 with MODE_SA31_EN=1): rem=1 if MC[4]=1, else 0.
  - Otherwise rem=WC, with WC=0 meaning 32. rem is 6 bits wide.
- CMD:
  - m_axis_tvalid=1, tdata=command, tuser={3'b100,2'b00,1'b1,1'b0,p}.
  - p = inject bit if rem=0, else 0.
  - On m_axis_tready: go to DONE if rem=0, else DATA.
- DATA:
  - Pass-through with an output register. Load a new word when !m_axis_tvalid || m_axis_tready.
  - s_dat_tready = (!m_axis_tvalid || m_axis_tready) && words_fetched<rem.
  - Data tuser={3'b010,2'b00,1'b0,1'b0,p}; p = inject bit on the final word only.
  - Each encoder accept decrements the outstanding count. The accept of the final word pulses msg_done on the following cycle and returns the block to IDLE.
- Data timeout:
  - The timeout counter resets on every s_dat accept and counts while DATA is waiting for a data word.
  - Reaching TIMEOUT_CYCLES-1: drop any unsent word, deassert m_axis_tvalid, go to ERR.
- ERR: pulse msg_err, increment err_count (saturating at 255), go to IDLE next cycle. Data words not consumed remain in the upstream stream.
- DONE: pulse msg_done, go to IDLE.
- busy=1 in all states except IDLE.
- m_axis_tvalid, once asserted, holds with stable tdata/tuser until m_axis_tready (AXIS rule). The timeout abort is the only exception and may occur only while tvalid=0.
- A new descriptor is not accepted until IDLE. Minimum spacing is one IDLE cycle between messages.

Decomposition:
- Package axis_1553_pkg:
  - sync codes SYNC_CMD=3'b100, SYNC_DATA=3'b010
  - tuser bit indices
  - command-word field offsets
  - state enum
  - function wc_decode(cmd, sa31_en) returning 6-bit rem
- One sub-module is natural: axis_1553_out_reg, a 16+8-bit AXIS output register with load/hold. Everything else stays in the top.

Test Plan:
- Receive command 0x0822 (RT1, R, SA1, WC2), data 0x1234 then 0xABCD, encoder tready always 1 -> tuser sequence 0x84, 0x40, 0x40; msg_done pulses once; busy returns to 0.
- Transmit command 0x0C20 (T/R=1) -> exactly one word with tuser 0x84; s_dat_tready never asserted; msg_done pulses.
- Mode code 0x0011 (SA0, MC17) -> one data word follows. Mode code 0x0002 -> zero data words.
- WC=0 with T/R=0 -> 32 data words accepted. Encoder tready toggling every 3 cycles -> tdata/tuser held stable while stalled, all words in order.
- WC=3 with the data stream stalled after word 1 -> msg_err pulses TIMEOUT_CYCLES after the last accept; err_count=1; state returns to IDLE; the next message works normally.
- Inject bit set with WC=1 -> tuser[0]=1 on the data word only. Assert arstn=0 mid-DATA -> outputs 0, no msg_done or msg_err pulse.
